// File: rtl/dcache_sequencer.sv
// Direct-mapped, write-back, write-allocate sequencer between a 32-bit CPU port, a 512 x 128-bit
// line store and a 128-bit memory port. Define DCACHE_STATS_EN to build the hit/miss counters.
module dcache_sequencer #(
    parameter int CAS_WAIT_MAX = 64
) (
    input  logic         clk,
    input  logic         reset,
    // CPU port
    input  logic         cpu_req,
    input  logic         cpu_wren,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_rvalid,
    output logic         cpu_ready,
    // line store
    output logic [27:0]  cm_addr,
    output logic [127:0] cm_wdata,
    output logic         cm_wren,
    output logic         cm_mark_dirty,
    input  logic [127:0] cm_rdata,
    input  logic [18:0]  cm_tag,
    input  logic         cm_dirty,
    input  logic         cm_valid,
    // backing memory
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    output logic         mem_wren,
    output logic         mem_rd,
    input  logic [127:0] mem_rdata,
    input  logic         mem_rvalid,
    input  logic         mem_ready,
    // statistics
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_misses
);

    localparam int WD_W = $clog2(CAS_WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_ALLOCATE
    } state_e;

    state_e         state_q, state_d;
    logic [27:0]    line_addr_q, line_addr_d;
    logic [1:0]     word_q, word_d;
    logic           wren_q, wren_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [31:0]    cpu_rdata_q, cpu_rdata_d;
    logic           cpu_rvalid_q, cpu_rvalid_d;
    logic           cm_wren_q, cm_wren_d;
    logic           cm_mark_dirty_q, cm_mark_dirty_d;
    logic [127:0]   cm_wdata_q, cm_wdata_d;

    logic [18:0]    req_tag;
    logic [8:0]     req_index;
    logic           hit;
    logic [31:0]    sel_word;
    logic [127:0]   merged_line;

    // Byte offset within a word is irrelevant to a word-granular cache.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_tag   = line_addr_q[27:9];
    assign req_index = line_addr_q[8:0];
    assign hit       = cm_valid && (cm_tag == req_tag);

    assign cpu_ready     = (state_q == S_IDLE);
    assign cpu_rdata     = cpu_rdata_q;
    assign cpu_rvalid    = cpu_rvalid_q;
    assign cm_addr       = line_addr_q;
    assign cm_wdata      = cm_wdata_q;
    assign cm_wren       = cm_wren_q;
    assign cm_mark_dirty = cm_mark_dirty_q;

    always_comb begin
        sel_word    = cm_rdata[31:0];
        merged_line = cm_rdata;
        case (word_q)
            2'd0: sel_word = cm_rdata[31:0];
            2'd1: sel_word = cm_rdata[63:32];
            2'd2: sel_word = cm_rdata[95:64];
            2'd3: sel_word = cm_rdata[127:96];
            default: sel_word = cm_rdata[31:0];
        endcase
        for (int w = 0; w < 4; w++) begin
            if (word_q == 2'(w)) begin
                merged_line[w*32 +: 32] = wdata_q;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d         = state_q;
        line_addr_d     = line_addr_q;
        word_d          = word_q;
        wren_d          = wren_q;
        wdata_d         = wdata_q;
        wd_d            = wd_q;
        cpu_rdata_d     = cpu_rdata_q;
        cpu_rvalid_d    = 1'b0;
        cm_wren_d       = 1'b0;
        cm_mark_dirty_d = 1'b0;
        cm_wdata_d      = cm_wdata_q;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_wren        = 1'b0;
        mem_rd          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    line_addr_d = cpu_addr[31:4];
                    word_d      = cpu_addr[3:2];
                    wren_d      = cpu_wren;
                    wdata_d     = cpu_wdata;
                    state_d     = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    if (wren_q) begin
                        cm_wren_d       = 1'b1;
                        cm_mark_dirty_d = 1'b1;
                        cm_wdata_d      = merged_line;
                    end else begin
                        cpu_rdata_d  = sel_word;
                        cpu_rvalid_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (cm_valid && cm_dirty) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_REFILL_REQ;
                end
            end
            S_WRITEBACK: begin
                // Victim address comes from the stored tag, not the requested one.
                mem_addr  = {cm_tag, req_index, 4'h0};
                mem_wdata = cm_rdata;
                if (mem_ready) begin
                    mem_wren = 1'b1;
                    state_d  = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                mem_addr = {req_tag, req_index, 4'h0};
                if (mem_ready) begin
                    mem_rd  = 1'b1;
                    wd_d    = '0;
                    state_d = S_REFILL_WAIT;
                end
            end
            S_REFILL_WAIT: begin
                if (mem_rvalid) begin
                    cm_wdata_d = mem_rdata;
                    cm_wren_d  = 1'b1;
                    state_d    = S_ALLOCATE;
                end else if (wd_q == WD_W'(CAS_WAIT_MAX - 1)) begin
                    state_d = S_REFILL_REQ;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_ALLOCATE: begin
                // The line write lands at the end of this cycle; the re-lookup then hits.
                state_d = S_COMPARE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            line_addr_q     <= '0;
            word_q          <= '0;
            wren_q          <= 1'b0;
            wdata_q         <= '0;
            wd_q            <= '0;
            cpu_rdata_q     <= '0;
            cpu_rvalid_q    <= 1'b0;
            cm_wren_q       <= 1'b0;
            cm_mark_dirty_q <= 1'b0;
            cm_wdata_q      <= '0;
        end else begin
            state_q         <= state_d;
            line_addr_q     <= line_addr_d;
            word_q          <= word_d;
            wren_q          <= wren_d;
            wdata_q         <= wdata_d;
            wd_q            <= wd_d;
            cpu_rdata_q     <= cpu_rdata_d;
            cpu_rvalid_q    <= cpu_rvalid_d;
            cm_wren_q       <= cm_wren_d;
            cm_mark_dirty_q <= cm_mark_dirty_d;
            cm_wdata_q      <= cm_wdata_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;
    logic        relookup_q, relookup_d;
    logic        count_hit, count_miss;

    // A COMPARE entered from ALLOCATE is the re-lookup of an already counted miss.
    assign relookup_d = (state_q == S_ALLOCATE);
    assign count_hit  = (state_q == S_COMPARE) && hit && !relookup_q;
    assign count_miss = (state_q == S_COMPARE) && !hit;

    always_comb begin
        hits_d   = hits_q + {31'd0, count_hit};
        misses_d = misses_q + {31'd0, count_miss};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q     <= '0;
            misses_q   <= '0;
            relookup_q <= 1'b0;
        end else begin
            hits_q     <= hits_d;
            misses_q   <= misses_d;
            relookup_q <= relookup_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_dcache_sequencer.sv
// Directed bench for dcache_sequencer: behavioural line store, hand-driven memory responses,
// and immediate-assertion checks of every expected value.
module tb_dcache_sequencer;

    localparam int CAS = 8;
`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         cpu_req, cpu_wren;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_rvalid, cpu_ready;
    logic [27:0]  cm_addr;
    logic [127:0] cm_wdata, cm_rdata;
    logic         cm_wren, cm_mark_dirty;
    logic [18:0]  cm_tag;
    logic         cm_dirty, cm_valid;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_wren, mem_rd, mem_rvalid, mem_ready;
    logic [31:0]  stat_hits, stat_misses;

    dcache_sequencer #(.CAS_WAIT_MAX(CAS)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_ready(cpu_ready),
        .cm_addr(cm_addr), .cm_wdata(cm_wdata), .cm_wren(cm_wren), .cm_mark_dirty(cm_mark_dirty),
        .cm_rdata(cm_rdata), .cm_tag(cm_tag), .cm_dirty(cm_dirty), .cm_valid(cm_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_ready(mem_ready),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural line store: combinational read, write at the clock edge.
    logic         ls_clr;
    logic [127:0] ls_data  [512];
    logic [18:0]  ls_tag   [512];
    logic         ls_valid [512];
    logic         ls_dirty [512];

    assign cm_rdata = ls_data[cm_addr[8:0]];
    assign cm_tag   = ls_tag[cm_addr[8:0]];
    assign cm_valid = ls_valid[cm_addr[8:0]];
    assign cm_dirty = ls_dirty[cm_addr[8:0]];

    always @(posedge clk) begin
        if (ls_clr) begin
            for (int i = 0; i < 512; i++) begin
                ls_data[i]  <= '0;
                ls_tag[i]   <= '0;
                ls_valid[i] <= 1'b0;
                ls_dirty[i] <= 1'b0;
            end
        end else if (cm_wren) begin
            ls_data[cm_addr[8:0]]  <= cm_wdata;
            ls_tag[cm_addr[8:0]]   <= cm_addr[27:9];
            ls_valid[cm_addr[8:0]] <= 1'b1;
            ls_dirty[cm_addr[8:0]] <= cm_mark_dirty;
        end
    end

    // Event monitor, sampled mid-cycle.
    int           n_rd = 0, n_wr = 0, n_cmw = 0, n_rv = 0, n_viol = 0;
    int           rd_cyc = 0, wr_cyc = 0, rv_cyc = 0;
    logic [31:0]  rd_addr = '0, wr_addr = '0, rv_data = '0;
    logic [127:0] wr_data = '0, cmw_data = '0;
    logic         cmw_dirty = 1'b0;

    always @(negedge clk) begin
        if (mem_rd) begin
            n_rd    <= n_rd + 1;
            rd_addr <= mem_addr;
            rd_cyc  <= cyc;
        end
        if (mem_wren) begin
            n_wr    <= n_wr + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
            wr_cyc  <= cyc;
        end
        if (cm_wren) begin
            n_cmw     <= n_cmw + 1;
            cmw_data  <= cm_wdata;
            cmw_dirty <= cm_mark_dirty;
        end
        if (cpu_rvalid) begin
            n_rv    <= n_rv + 1;
            rv_data <= cpu_rdata;
            rv_cyc  <= cyc;
        end
        if ((mem_rd || mem_wren) && (!mem_ready || (mem_rd && mem_wren))) n_viol <= n_viol + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int req_cyc = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat_exp(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int i = 0;
        while (!cpu_ready && i < 300) begin
            tick();
            i++;
        end
        check({tag, "_ready"}, cpu_ready, 1'b1);
    endtask

    task automatic wait_rd(input int target, input string tag);
        int i = 0;
        while (n_rd < target && i < 300) begin
            tick();
            i++;
        end
        check({tag, "_rd_seen"}, (n_rd >= target), 1'b1);
    endtask

    task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        wait_ready("pre_access");
        cpu_req   = 1'b1;
        cpu_wren  = wr;
        cpu_addr  = addr;
        cpu_wdata = data;
        req_cyc   = cyc;
        tick();
        cpu_req   = 1'b0;
    endtask

    task automatic serve(input int target, input logic [127:0] data, input int lat, input string tag);
        wait_rd(target, tag);
        repeat (lat) tick();
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
    endtask

    localparam logic [127:0] D1 = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    localparam logic [127:0] D1_ST = {32'hA3A3_0003, 32'hDEAD_BEEF, 32'hA1A1_0001, 32'hA0A0_0000};
    localparam logic [127:0] D2 = {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000};
    localparam logic [127:0] D3 = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
    localparam logic [127:0] D4 = {32'hE3E3_0003, 32'hE2E2_0002, 32'hE1E1_0001, 32'hE0E0_0000};

    initial begin
        int base_rd, base_wr, base_cmw, base_rv, ready_cyc, r1;
        reset      = 1'b1;
        ls_clr     = 1'b1;
        cpu_req    = 1'b0;
        cpu_wren   = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        mem_ready  = 1'b1;
        repeat (3) tick();
        ls_clr = 1'b0;

        // Reset state
        check("rst_ready",  cpu_ready, 1'b1);
        check("rst_rvalid", cpu_rvalid, 1'b0);
        check("rst_rdata",  cpu_rdata, 32'd0);
        check("rst_cm",     {cm_wren, cm_mark_dirty, cm_addr}, '0);
        check("rst_cmw",    cm_wdata, '0);
        check("rst_mem",    {mem_wren, mem_rd, mem_addr}, '0);
        check("rst_memw",   mem_wdata, '0);
        check("rst_stats",  {stat_hits, stat_misses}, '0);
        reset = 1'b0;
        tick();

        // Cold load 0x1234: clean miss, refill, word 1 returned
        cpu_access(1'b0, 32'h0000_1234, '0);
        serve(1, D1, 3, "cold");
        wait_ready("cold");
        tick();
        check("cold_nrd",     n_rd, 1);
        check("cold_rdaddr",  rd_addr, 32'h0000_1230);
        check("cold_nwr",     n_wr, 0);
        check("cold_ncmw",    n_cmw, 1);
        check("cold_cmdirty", cmw_dirty, 1'b0);
        check("cold_cmdata",  cmw_data, D1);
        check("cold_nrv",     n_rv, 1);
        check("cold_rdata",   rv_data, 32'hA1A1_0001);
        check("cold_misses",  stat_misses, stat_exp(1));
        check("cold_hits",    stat_hits, stat_exp(0));

        // Load hit: rvalid two cycles after the request cycle, no memory traffic
        cpu_access(1'b0, 32'h0000_1234, '0);
        wait_ready("hit");
        tick();
        check("hit_latency", rv_cyc, req_cyc + 2);
        check("hit_rdata",   rv_data, 32'hA1A1_0001);
        check("hit_nrd",     n_rd, 1);
        check("hit_hits",    stat_hits, stat_exp(1));

        // Store hit to word 2, then reload word 2 and word 1
        base_rv = n_rv;
        cpu_access(1'b1, 32'h0000_1238, 32'hDEAD_BEEF);
        wait_ready("st");
        tick();
        check("st_ncmw",   n_cmw, 2);
        check("st_dirty",  cmw_dirty, 1'b1);
        check("st_data",   cmw_data, D1_ST);
        check("st_norv",   n_rv, base_rv);
        cpu_access(1'b0, 32'h0000_1238, '0);
        wait_ready("ld2");
        tick();
        check("ld_w2",     rv_data, 32'hDEAD_BEEF);
        cpu_access(1'b0, 32'h0000_1234, '0);
        wait_ready("ld1");
        tick();
        check("ld_w1",     rv_data, 32'hA1A1_0001);
        check("st_hits",   stat_hits, stat_exp(4));

        // Dirty eviction: load 0x3230 hits index 0x123 with tag 1
        base_rd = n_rd;
        base_wr = n_wr;
        cpu_access(1'b0, 32'h0000_3230, '0);
        serve(base_rd + 1, D2, 2, "evict");
        wait_ready("evict");
        tick();
        check("ev_nwr",    n_wr, base_wr + 1);
        check("ev_wraddr", wr_addr, 32'h0000_1230);
        check("ev_wrword", wr_data[95:64], 32'hDEAD_BEEF);
        check("ev_wrdata", wr_data, D1_ST);
        check("ev_rdaddr", rd_addr, 32'h0000_3230);
        check("ev_order",  (wr_cyc < rd_cyc), 1'b1);
        check("ev_rdata",  rv_data, 32'hB0B0_0000);
        check("ev_clean",  cmw_dirty, 1'b0);
        check("ev_misses", stat_misses, stat_exp(2));

        // Memory back-pressure: mem_rd held off for 10 cycles
        mem_ready = 1'b0;
        base_rd   = n_rd;
        cpu_access(1'b0, 32'h0000_5670, '0);
        repeat (10) tick();
        check("bp_held",   n_rd, base_rd);
        mem_ready = 1'b1;
        ready_cyc = cyc;
        serve(base_rd + 1, D3, 2, "bp");
        wait_ready("bp");
        tick();
        check("bp_once",   n_rd, base_rd + 1);
        check("bp_first",  rd_cyc, ready_cyc);
        check("bp_rdaddr", rd_addr, 32'h0000_5670);
        check("bp_rdata",  rv_data, 32'hC0C0_0000);
        check("bp_misses", stat_misses, stat_exp(3));

        // Reset while in REFILL_WAIT, then a late mem_rvalid
        base_rd = n_rd;
        cpu_access(1'b0, 32'h0000_9AB0, '0);
        wait_rd(base_rd + 1, "rst_mid");
        tick();
        base_cmw = n_cmw;
        base_rv  = n_rv;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_ready",  cpu_ready, 1'b1);
        check("rm_strobe", {mem_rd, mem_wren, cm_wren, cpu_rvalid}, 4'b0000);
        mem_rvalid = 1'b1;
        mem_rdata  = D4;
        tick();
        mem_rvalid = 1'b0;
        repeat (4) tick();
        check("rm_nocmw",  n_cmw, base_cmw);
        check("rm_norv",   n_rv, base_rv);
        check("rm_idle",   cpu_ready, 1'b1);
        check("rm_stats",  {stat_hits, stat_misses}, '0);

        // Line store kept its contents across reset: 0x3230 hits
        cpu_access(1'b0, 32'h0000_3230, '0);
        wait_ready("post_rst");
        tick();
        check("pr_rdata",  rv_data, 32'hB0B0_0000);
        check("pr_hits",   stat_hits, stat_exp(1));

        // Watchdog: no refill data, mem_rd retried after CAS_WAIT_MAX cycles
        base_rd = n_rd;
        cpu_access(1'b0, 32'h0000_9AB0, '0);
        wait_rd(base_rd + 1, "wd1");
        r1 = rd_cyc;
        wait_rd(base_rd + 2, "wd2");
        check("wd_retry",  rd_cyc - r1, CAS + 1);
        check("wd_addr",   rd_addr, 32'h0000_9AB0);
        mem_rvalid = 1'b1;
        mem_rdata  = D4;
        tick();
        mem_rvalid = 1'b0;
        wait_ready("wd");
        tick();
        check("wd_nrd",    n_rd, base_rd + 2);
        check("wd_rdata",  rv_data, 32'hE0E0_0000);
        check("wd_misses", stat_misses, stat_exp(1));

        check("protocol",  n_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound in case a sequence stalls outside a bounded wait.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dcache_sequencer.md
# dcache_sequencer

Direct-mapped, write-back, write-allocate cache controller that sequences the 512-line × 128-bit cache line store and the 128-bit backing-memory port on behalf of a single 32-bit CPU requester. It performs the hit/miss decision, dirty-victim writeback, line refill and word merge. It sits between the CPU load/store port and the cache line store and main-memory model, and it owns every control strobe of both.

## Interface
- `CAS_WAIT_MAX`, default 64: refill watchdog; cycles waited for `mem_rvalid` before retrying `mem_rd`.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset is synchronous, active-high; clock is clk.
- `cpu_req` input, 1 bit: request strobe. Sampled only while `cpu_ready`=1.
- `cpu_wren` input, 1 bit: 1 = store, 0 = load.
- `cpu_addr` input, 32 bits: byte address. [31:13] tag, [12:4] index, [3:2] word; [1:0] ignored.
- `cpu_wdata` input, 32 bits: store data.
- `cpu_rdata` output, 32 bits: load data. Registered.
- `cpu_rvalid` output, 1 bit: 1-cycle pulse marking `cpu_rdata` valid.
- `cpu_ready` output, 1 bit: 1 only in IDLE.
- `cm_addr` output, 28 bits: line address {tag, index} to the line store.
- `cm_wdata` output, 128 bits: line write data.
- `cm_wren` output, 1 bit: line store write strobe.
- `cm_mark_dirty` output, 1 bit: dirty bit value written with `cm_wren`.
- `cm_rdata` input, 128 bits: combinational line read data.
- `cm_tag` input, 19 bits: stored tag.
- `cm_dirty` input, 1 bit: stored dirty bit.
- `cm_valid` input, 1 bit: stored valid bit.
- `mem_addr` output, 32 bits: line-aligned byte address; [3:0]=0.
- `mem_wdata` output, 128 bits: victim line.
- `mem_wren` output, 1 bit: 1-cycle write pulse.
- `mem_rd` output, 1 bit: 1-cycle read pulse.
- `mem_rdata` input, 128 bits: refill line.
- `mem_rvalid` input, 1 bit: refill data valid.
- `mem_ready` input, 1 bit: memory accepts a pulse this cycle.
- `stat_hits` output, 32 bits: hit counter.
- `stat_misses` output, 32 bits: miss counter.

## Operation
- States: IDLE, COMPARE, WRITEBACK, REFILL_REQ, REFILL_WAIT, ALLOCATE.
- IDLE: when `cpu_req`=1, latch addr, wren and wdata, then go to COMPARE. `cm_addr` always presents the latched line address.
- COMPARE: a hit is `cm_valid` && `cm_tag` == tag.
  - Load hit: `cpu_rdata` ← `cm_rdata` word [addr[3:2]] (word 0 = bits [31:0]); `cpu_rvalid` pulses; go to IDLE.
  - Store hit: assert `cm_wren`, `cm_mark_dirty`=1, and `cm_wdata` = `cm_rdata` with the selected word replaced; go to IDLE. There is no `cpu_rvalid` for stores.
  - Miss with `cm_valid`&&`cm_dirty`: go to WRITEBACK. Any other miss goes to REFILL_REQ.
- WRITEBACK: wait for `mem_ready`. Then pulse `mem_wren` with `mem_addr` = {`cm_tag`, index, 4'h0} and `mem_wdata` = `cm_rdata`; go to REFILL_REQ.
- REFILL_REQ: wait for `mem_ready`. Then pulse `mem_rd` with `mem_addr` = {tag, index, 4'h0}; clear the watchdog; go to REFILL_WAIT.
- REFILL_WAIT: on `mem_rvalid`, capture `mem_rdata` and go to ALLOCATE. If the watchdog reaches `CAS_WAIT_MAX`, return to REFILL_REQ.
- ALLOCATE: assert `cm_wren` with the captured line and `cm_mark_dirty`=0; go to COMPARE. The re-lookup then hits and completes the access. This is the only path to allocation.
- `mem_rvalid` outside REFILL_WAIT is ignored.
- `cpu_req` while `cpu_ready`=0 is ignored. The requester holds the request until it is accepted.
- Counters:
  - `stat_hits` increments on a COMPARE hit, except the re-lookup that follows ALLOCATE.
  - `stat_misses` increments on each COMPARE miss.
  - Both counters wrap at 2^32.

## Timing
- Reset values:
  - State is IDLE and `cpu_ready`=1.
  - `cpu_rdata`=0, `cpu_rvalid`=0.
  - `cm_wren`=0, `cm_mark_dirty`=0, `cm_addr`=0, `cm_wdata`=0.
  - `mem_wren`=0, `mem_rd`=0, `mem_addr`=0, `mem_wdata`=0.
  - `stat_hits`=0, `stat_misses`=0.
- Hit latency: request accepted at edge N; `cpu_rvalid` (load) or the line write (store) occurs in cycle N+1 → N+2; `cpu_ready` returns in cycle N+2.
- Clean miss: IDLE, COMPARE, REFILL_REQ, then REFILL_WAIT for L cycles (memory CAS latency), then ALLOCATE, COMPARE, IDLE. A dirty miss adds one WRITEBACK cycle plus any `mem_ready` stall.
- Reset mid-operation: next state is IDLE and all strobes are deasserted in the following cycle. A late `mem_rvalid` is dropped. Line-store contents are untouched by this block.
- `mem_wren` and `mem_rd` are never asserted in the same cycle. Neither is asserted while `mem_ready`=0.

## Configuration
- `DCACHE_STATS_EN` defined: `stat_hits` and `stat_misses` count as specified.
- `DCACHE_STATS_EN` undefined: both outputs are tied to 0 and no counter registers are inferred. All other behaviour is identical.

## Test plan
- Cold load: reset, load 0x0000_1234 → one `mem_rd` with `mem_addr`=0x0000_1230 and no `mem_wren`. After `mem_rvalid`, `cm_wren` occurs with `cm_mark_dirty`=0, then `cpu_rvalid` with `cpu_rdata` = `mem_rdata`[63:32]. `stat_misses`=1.
- Load hit: repeat load 0x0000_1234 → `cpu_rvalid` exactly 2 cycles after acceptance with the same word, no `mem_rd`, `stat_hits`=1.
- Store hit then load: store 0xDEAD_BEEF to 0x0000_1238 → `cm_wren` with `cm_mark_dirty`=1. A following load of 0x0000_1238 returns 0xDEAD_BEEF, and word 1 is unchanged.
- Dirty eviction: after the above, load 0x0000_3230 (same index 0x123, different tag) → `mem_wren` with `mem_addr`=0x0000_1230 and `mem_wdata`[95:64]=0xDEAD_BEEF, then `mem_rd` with `mem_addr`=0x0000_3230, in that order.
- Reset during REFILL_WAIT: assert `reset` for 1 cycle, then drive `mem_rvalid` → no `cm_wren`, no `cpu_rvalid`, and `cpu_ready`=1 in the cycle after reset.
- Memory back-pressure: hold `mem_ready`=0 for 10 cycles on a miss → `mem_rd` is held off and then pulses exactly once in the first cycle that `mem_ready`=1.
